// File: rtl/cr_huf_comp_st_fsm_mc_pkg.sv
// Shared types for the Huffman compressor symbol-table sequencing logic.
// The per-channel state encoding is fixed at 3 bits because other blocks decode these values.
package cr_huf_compPKG;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    RDY_TO_SA     = 3'd1,
    TBL_RDY_TO_SA = 3'd2,
    START_STCL    = 3'd3,
    WAIT_STCL     = 3'd4
  } e_st_state;

  localparam int ST_W = 3;

endpackage

// File: rtl/cr_huf_comp_st_fsm_mc_arb.sv
// Round-robin picker for the shared STCL writer.
// The search starts at ptr+1 and wraps, so the last owner is considered last.
module cr_huf_comp_st_rr_arb #(
  parameter int N_CH = 2,
  parameter int CH_W = 1
) (
  input  logic [N_CH-1:0] req,
  input  logic [CH_W-1:0] ptr,
  output logic            any,
  output logic [N_CH-1:0] gnt_oh,
  output logic [CH_W-1:0] gnt_idx
);

  int unsigned     idx;
  logic [N_CH-1:0] sel;

  always_comb begin
    any     = 1'b0;
    gnt_oh  = '0;
    gnt_idx = '0;
    idx     = 0;
    sel     = '0;
    for (int unsigned k = 1; k <= N_CH; k++) begin
      idx = (32'(ptr) + k) % N_CH;
      sel = N_CH'(1) << idx;
      if (!any && ((req & sel) != '0)) begin
        any     = 1'b1;
        gnt_oh  = sel;
        gnt_idx = CH_W'(idx);
      end
    end
  end

endmodule

// File: rtl/cr_huf_comp_st_fsm_mc.sv
// Multi-channel symbol-table sequencing FSM: one state machine and stall counter per channel,
// plus a single round-robin grant for the shared STCL LUT writer.
module cr_huf_comp_st_fsm_mc
  import cr_huf_compPKG::*;
#(
  parameter int N_CH = 2,
  parameter int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1,
  parameter int TO_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_CH-1:0]      tw_pass_thru_rdy,
  input  logic [N_CH-1:0]      tw_code_rdy,
  input  logic [N_CH-1:0]      st_st_lut_wr_done,
  input  logic                 st_stcl_lut_wr_done,
  input  logic [N_CH-1:0]      sa_st_read_done,
  input  logic [N_CH-1:0]      st_flush,
  input  logic [TO_W-1:0]      cfg_timeout,
  output logic [N_CH*ST_W-1:0] st_curr_st,
  output logic [N_CH*ST_W-1:0] st_nxt_st,
  output logic                 st_stcl_gnt_vld,
  output logic [CH_W-1:0]      st_stcl_gnt_ch,
  output logic [N_CH-1:0]      st_timeout_err
);

  logic            gnt_vld_q, gnt_vld_d;
  logic [CH_W-1:0] gnt_ch_q, gnt_ch_d;
  logic [CH_W-1:0] rr_ptr_q, rr_ptr_d;

  logic [N_CH-1:0] req_vec;
  logic [N_CH-1:0] leave_vec;
  logic [N_CH-1:0] arb_oh;
  logic [CH_W-1:0] arb_idx;
  logic            arb_any;
  logic            grant_fire;
  logic [N_CH-1:0] grant_oh;

  cr_huf_comp_st_rr_arb #(
    .N_CH (N_CH),
    .CH_W (CH_W)
  ) u_arb (
    .req     (req_vec),
    .ptr     (rr_ptr_q),
    .any     (arb_any),
    .gnt_oh  (arb_oh),
    .gnt_idx (arb_idx)
  );

  // A new owner is only chosen while the writer is free, which leaves a gap cycle after release.
  assign grant_fire = !gnt_vld_q && arb_any;
  assign grant_oh   = arb_oh & {N_CH{grant_fire}};

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      e_st_state       st_q, st_d;
      logic [TO_W-1:0] cnt_q, cnt_d;
      logic            err_q, err_d;
      logic            to_hit;
      logic            is_owner;

      assign is_owner = gnt_vld_q && (gnt_ch_q == CH_W'(gi));
      assign to_hit   = (cfg_timeout != '0) && (st_q != ST_IDLE) &&
                        (cnt_q == cfg_timeout - TO_W'(1));

      // A channel being flushed or timed out must not win the writer on its way out.
      assign req_vec[gi]   = (st_q == WAIT_STCL) && !st_flush[gi] && !to_hit;
      assign leave_vec[gi] = is_owner && (st_d != START_STCL);

      always_comb begin
        st_d = st_q;
        if (st_flush[gi] || to_hit) begin
          st_d = ST_IDLE;
        end else begin
          case (st_q)
            ST_IDLE: begin
              if (tw_pass_thru_rdy[gi])  st_d = RDY_TO_SA;
              else if (tw_code_rdy[gi])  st_d = WAIT_STCL;
            end
            WAIT_STCL: begin
              if (grant_oh[gi]) st_d = START_STCL;
            end
            START_STCL: begin
              if (st_stcl_lut_wr_done && is_owner) st_d = RDY_TO_SA;
            end
            RDY_TO_SA: begin
              if (sa_st_read_done[gi])        st_d = ST_IDLE;
              else if (st_st_lut_wr_done[gi]) st_d = TBL_RDY_TO_SA;
            end
            TBL_RDY_TO_SA: begin
              if (sa_st_read_done[gi]) st_d = ST_IDLE;
            end
            default: st_d = ST_IDLE;
          endcase
        end
      end

      always_comb begin
        cnt_d = cnt_q;
        if (st_d != st_q)                              cnt_d = '0;
        else if ((st_q != ST_IDLE) && (cnt_q != '1))   cnt_d = cnt_q + TO_W'(1);
        err_d = to_hit && !st_flush[gi];
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          st_q  <= ST_IDLE;
          cnt_q <= '0;
          err_q <= 1'b0;
        end else begin
          st_q  <= st_d;
          cnt_q <= cnt_d;
          err_q <= err_d;
        end
      end

      assign st_curr_st[ST_W*gi +: ST_W] = st_q;
      assign st_nxt_st[ST_W*gi +: ST_W]  = st_d;
      assign st_timeout_err[gi]          = err_q;
    end
  endgenerate

  always_comb begin
    gnt_vld_d = gnt_vld_q;
    gnt_ch_d  = gnt_ch_q;
    rr_ptr_d  = rr_ptr_q;
    if (gnt_vld_q) begin
      if (leave_vec != '0) gnt_vld_d = 1'b0;
    end else if (arb_any) begin
      gnt_vld_d = 1'b1;
      gnt_ch_d  = arb_idx;
      rr_ptr_d  = arb_idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_vld_q <= 1'b0;
      gnt_ch_q  <= '0;
      rr_ptr_q  <= CH_W'(N_CH - 1);
    end else begin
      gnt_vld_q <= gnt_vld_d;
      gnt_ch_q  <= gnt_ch_d;
      rr_ptr_q  <= rr_ptr_d;
    end
  end

  assign st_stcl_gnt_vld = gnt_vld_q;
  assign st_stcl_gnt_ch  = gnt_ch_q;

endmodule
